rp_tag_scheduler: RTL

Root-port BFM tag scheduler: shares the RP non-posted tag space among several requesters (MMIO read tasks, DMA-checker tasks) that issue requests onto the RX request TLP channel. It arbitrates requesters round-robin, allocates a free tag per grant, and matches completions back to the owning requester. Per-tag timers detect completions that never arrive. It sits beside the packet sender and completion receiver inside the tester and replaces ad hoc `tag_active` bookkeeping.

---
 rtl/rp_tag_scheduler.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/rp_tag_scheduler.sv
// rtl/rp_tag_scheduler.sv - RP non-posted tag scheduler: round-robin grant, tag allocation,
// completion matching and per-tag timeout detection.
module rp_tag_scheduler #(
   parameter int NUM_REQ     = 4,
   parameter int NUM_TAGS    = 64,
   parameter int TAG_W       = $clog2(NUM_TAGS),
   parameter int TIMEOUT_CYC = 4096,
   localparam int IDX_W      = $clog2(NUM_REQ),
   localparam int AGE_W      = $clog2(TIMEOUT_CYC)
) (
   input  logic               avl_clk,
   input  logic               avl_rst,
   input  logic [NUM_REQ-1:0] i_req_valid,
   output logic [NUM_REQ-1:0] o_req_grant,
   output logic [TAG_W-1:0]   o_grant_tag,
   input  logic               i_cpl_valid,
   input  logic [TAG_W-1:0]   i_cpl_tag,
   input  logic               i_cpl_last,
   output logic               o_cpl_valid,
   output logic [IDX_W-1:0]   o_cpl_req_idx,
   output logic               o_cpl_unexp,
   output logic               o_timeout_valid,
   output logic [TAG_W-1:0]   o_timeout_tag,
   output logic [IDX_W-1:0]   o_timeout_req_idx,
   output logic [TAG_W:0]     o_free_cnt,
   output logic               o_idle
);

   localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(TIMEOUT_CYC - 1);
   localparam logic [TAG_W:0]   POOL_CNT = (TAG_W + 1)'(NUM_TAGS);

   logic [NUM_TAGS-1:0] active_q, active_d;
   logic [IDX_W-1:0]    owner_q [NUM_TAGS];
   logic [IDX_W-1:0]    owner_d [NUM_TAGS];
   logic [AGE_W-1:0]    age_q   [NUM_TAGS];
   logic [AGE_W-1:0]    age_d   [NUM_TAGS];
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [TAG_W:0]      active_cnt_q, active_cnt_d;

   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [TAG_W-1:0]    grant_tag_q, grant_tag_d;
   logic                cpl_valid_q, cpl_valid_d;
   logic [IDX_W-1:0]    cpl_idx_q, cpl_idx_d;
   logic                cpl_unexp_q, cpl_unexp_d;
   logic                to_valid_q, to_valid_d;
   logic [TAG_W-1:0]    to_tag_q, to_tag_d;
   logic [IDX_W-1:0]    to_idx_q, to_idx_d;

   logic                req_found;
   logic [IDX_W-1:0]    req_idx;
   logic                free_found;
   logic [TAG_W-1:0]    free_tag;
   logic                to_found;
   logic [TAG_W-1:0]    to_tag;
   logic                cpl_hit;
   logic                cpl_miss;
   logic                grant_fire;

   // Descending scans let the lowest candidate overwrite, so the last hit is the winner.
   always_comb begin
      int j;
      req_found = 1'b0;
      req_idx   = '0;
      j         = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = int'(rr_ptr_q) + k;
         if (j >= NUM_REQ) begin
            j = j - NUM_REQ;
         end
         if (i_req_valid[IDX_W'(j)]) begin
            req_found = 1'b1;
            req_idx   = IDX_W'(j);
         end
      end
   end

   always_comb begin
      free_found = 1'b0;
      free_tag   = '0;
      for (int t = NUM_TAGS - 1; t >= 0; t--) begin
         if (!active_q[TAG_W'(t)]) begin
            free_found = 1'b1;
            free_tag   = TAG_W'(t);
         end
      end
   end

   assign cpl_hit  = i_cpl_valid &&  active_q[i_cpl_tag];
   assign cpl_miss = i_cpl_valid && !active_q[i_cpl_tag];

   // A completion landing on an expired tag pre-empts its timeout report.
   always_comb begin
      to_found = 1'b0;
      to_tag   = '0;
      for (int t = NUM_TAGS - 1; t >= 0; t--) begin
         if (active_q[TAG_W'(t)] && (age_q[TAG_W'(t)] == AGE_MAX) &&
             !(cpl_hit && (i_cpl_tag == TAG_W'(t)))) begin
            to_found = 1'b1;
            to_tag   = TAG_W'(t);
         end
      end
   end

   assign grant_fire = req_found && free_found;

   always_comb begin
      active_d = active_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      for (int t = 0; t < NUM_TAGS; t++) begin
         age_d[t] = age_q[t];
         if (active_q[TAG_W'(t)] && (age_q[t] != AGE_MAX)) begin
            age_d[t] = age_q[t] + 1'b1;
         end
      end

      if (cpl_hit) begin
         age_d[i_cpl_tag] = '0;
         if (i_cpl_last) begin
            active_d[i_cpl_tag] = 1'b0;
         end
      end

      if (to_found) begin
         active_d[to_tag] = 1'b0;
         age_d[to_tag]    = '0;
      end

      // The allocated tag is inactive now, so it cannot collide with a completion or timeout.
      if (grant_fire) begin
         active_d[free_tag] = 1'b1;
         owner_d[free_tag]  = req_idx;
         age_d[free_tag]    = '0;
         rr_ptr_d = (req_idx == IDX_W'(NUM_REQ - 1)) ? '0 : req_idx + 1'b1;
      end

      active_cnt_d = active_cnt_q
                   + (TAG_W + 1)'(grant_fire)
                   - (TAG_W + 1)'(cpl_hit && i_cpl_last)
                   - (TAG_W + 1)'(to_found);

      grant_d     = grant_fire ? (NUM_REQ'(1) << req_idx) : '0;
      grant_tag_d = grant_fire ? free_tag : '0;
      cpl_valid_d = cpl_hit;
      cpl_idx_d   = cpl_hit ? owner_q[i_cpl_tag] : '0;
      cpl_unexp_d = cpl_miss;
      to_valid_d  = to_found;
      to_tag_d    = to_found ? to_tag : '0;
      to_idx_d    = to_found ? owner_q[to_tag] : '0;
   end

   always_ff @(posedge avl_clk) begin
      if (avl_rst) begin
         active_q     <= '0;
         rr_ptr_q     <= '0;
         active_cnt_q <= '0;
         for (int t = 0; t < NUM_TAGS; t++) begin
            owner_q[t] <= '0;
            age_q[t]   <= '0;
         end
         grant_q      <= '0;
         grant_tag_q  <= '0;
         cpl_valid_q  <= 1'b0;
         cpl_idx_q    <= '0;
         cpl_unexp_q  <= 1'b0;
         to_valid_q   <= 1'b0;
         to_tag_q     <= '0;
         to_idx_q     <= '0;
      end else begin
         active_q     <= active_d;
         rr_ptr_q     <= rr_ptr_d;
         active_cnt_q <= active_cnt_d;
         owner_q      <= owner_d;
         age_q        <= age_d;
         grant_q      <= grant_d;
         grant_tag_q  <= grant_tag_d;
         cpl_valid_q  <= cpl_valid_d;
         cpl_idx_q    <= cpl_idx_d;
         cpl_unexp_q  <= cpl_unexp_d;
         to_valid_q   <= to_valid_d;
         to_tag_q     <= to_tag_d;
         to_idx_q     <= to_idx_d;
      end
   end

   assign o_req_grant       = grant_q;
   assign o_grant_tag       = grant_tag_q;
   assign o_cpl_valid       = cpl_valid_q;
   assign o_cpl_req_idx     = cpl_idx_q;
   assign o_cpl_unexp       = cpl_unexp_q;
   assign o_timeout_valid   = to_valid_q;
   assign o_timeout_tag     = to_tag_q;
   assign o_timeout_req_idx = to_idx_q;
   assign o_free_cnt        = POOL_CNT - active_cnt_q;
   assign o_idle            = (active_cnt_q == '0);

endmodule
